// File: rtl/ifetch_queue.sv
// Instruction-fetch front end.
// Issues sequential reads to a fixed-latency instruction memory. Each read's PC
// is tracked through a MEM_LAT-deep shift register. Returned instructions are
// buffered with their PCs in a DEPTH-entry FIFO, which drains to decode over a
// valid/ready handshake. A redirect (or reset) flushes the FIFO and every read
// in flight, then restarts fetch at the new PC.
module ifetch_queue #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter int                MEM_LAT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_ren,
  output logic [ADDR_W-1:0]          mem_raddr,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       halt,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_inst,
  output logic [ADDR_W-1:0]          out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Wide enough to hold occupancy + inflight without overflow.
  localparam int SUM_W = $clog2(DEPTH + MEM_LAT + 1) + 1;

  // Total credits in use: entries already queued plus reads still in flight.
  function automatic logic [SUM_W-1:0] credits_used(
    input logic [CNT_W-1:0]   occ,
    input logic [MEM_LAT-1:0] vld
  );
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(occ);
    for (int i = 0; i < MEM_LAT; i++) begin
      sum = sum + SUM_W'(vld[i]);
    end
    return sum;
  endfunction

  logic [ADDR_W-1:0] fetch_pc;
  logic [MEM_LAT-1:0] trk_vld;
  logic [ADDR_W-1:0] trk_pc [MEM_LAT];
  logic [DATA_W-1:0] fifo_inst [DEPTH];
  logic [ADDR_W-1:0] fifo_pc [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              flush;
  logic              issue;
  logic              push;
  logic              pop;

  // Issue, capture and pop decisions for this cycle.
  always_comb begin
    flush = rst || redirect;
    issue = !rst && !redirect && !halt &&
            (credits_used(count, trk_vld) < SUM_W'(DEPTH));
    push  = trk_vld[MEM_LAT-1];
    pop   = (count != '0) && out_ready;
  end

  // Fetch PC: reset / redirect reload, otherwise advance on every issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
    end else if (issue) begin
      fetch_pc <= fetch_pc + ADDR_W'(1);
    end
  end

  // ---- tracker stage boundary: read request -> response ----
  // Tracker valid bits; a flush drops every read still in flight.
  always_ff @(posedge clk) begin
    if (flush) begin
      trk_vld <= '0;
    end else begin
      trk_vld[0] <= issue;
      for (int i = 1; i < MEM_LAT; i++) begin
        trk_vld[i] <= trk_vld[i-1];
      end
    end
  end

  // Tracker PCs; meaningful only where the matching valid bit is set.
  always_ff @(posedge clk) begin
    trk_pc[0] <= fetch_pc;
    for (int i = 1; i < MEM_LAT; i++) begin
      trk_pc[i] <= trk_pc[i-1];
    end
  end

  // ---- FIFO stage boundary: captured response -> decode ----
  // FIFO pointers and count; flush empties the queue and wins over push/pop.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; a write during a flush lands in a slot that is then empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= mem_rdata;
      fifo_pc[wr_ptr]   <= trk_pc[MEM_LAT-1];
    end
  end

  // Credit accounting keeps pushes off a full FIFO; flag any breach.
  always_ff @(posedge clk) begin
    if (!flush && push && !pop) begin
      assert (count < CNT_W'(DEPTH));
    end
  end

  // Output drive: the head entry, forced to zero while the FIFO is empty.
  always_comb begin
    mem_ren   = issue;
    mem_raddr = fetch_pc;
    out_valid = (count != '0);
    occupancy = count;
    out_inst  = '0;
    out_pc    = '0;
    if (count != '0) begin
      out_inst = fifo_inst[rd_ptr];
      out_pc   = fifo_pc[rd_ptr];
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed checks on the default configuration, then a
// random-handshake scoreboard run on DEPTH=2/MEM_LAT=3 and DEPTH=8/MEM_LAT=1.
module tb_ifetch_queue;

  logic clk;
  int   passed;
  int   total;
  int   failed;

  // Default instance (DEPTH=4, MEM_LAT=2)
  logic        rst, redirect, halt, out_ready;
  logic [15:0] redirect_pc;
  logic        a_ren, a_vld;
  logic [15:0] a_raddr, a_rdata, a_inst, a_pc;
  logic [2:0]  a_occ;
  logic [15:0] a_p0, a_p1;

  // Sweep instances share one stimulus set
  logic        s_rst, s_redirect, s_halt, s_ready;
  logic [15:0] s_rpc;
  logic        b_ren, b_vld, c_ren, c_vld;
  logic [15:0] b_raddr, b_rdata, b_inst, b_pc;
  logic [15:0] c_raddr, c_rdata, c_inst, c_pc;
  logic [1:0]  b_occ;
  logic [3:0]  c_occ;
  logic [15:0] b_p0, b_p1, b_p2, c_p0;
  logic [15:0] exp_b, exp_c;
  int          pops_b, pops_c;

  ifetch_queue dut_a (
    .clk(clk), .rst(rst), .mem_ren(a_ren), .mem_raddr(a_raddr), .mem_rdata(a_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(a_vld), .out_inst(a_inst), .out_pc(a_pc), .out_ready(out_ready),
    .occupancy(a_occ));

  ifetch_queue #(.DEPTH(2), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(s_rst), .mem_ren(b_ren), .mem_raddr(b_raddr), .mem_rdata(b_rdata),
    .redirect(s_redirect), .redirect_pc(s_rpc), .halt(s_halt),
    .out_valid(b_vld), .out_inst(b_inst), .out_pc(b_pc), .out_ready(s_ready),
    .occupancy(b_occ));

  ifetch_queue #(.DEPTH(8), .MEM_LAT(1)) dut_c (
    .clk(clk), .rst(s_rst), .mem_ren(c_ren), .mem_raddr(c_raddr), .mem_rdata(c_rdata),
    .redirect(s_redirect), .redirect_pc(s_rpc), .halt(s_halt),
    .out_valid(c_vld), .out_inst(c_inst), .out_pc(c_pc), .out_ready(s_ready),
    .occupancy(c_occ));

  // Memory image: byte swap xor a constant, so inst never equals its PC.
  function automatic logic [15:0] img(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency memories; unrequested slots return a poison word.
  always @(posedge clk) begin
    a_p0 <= a_ren ? img(a_raddr) : 16'hDEAD;
    a_p1 <= a_p0;
    b_p0 <= b_ren ? img(b_raddr) : 16'hDEAD;
    b_p1 <= b_p0;
    b_p2 <= b_p1;
    c_p0 <= c_ren ? img(c_raddr) : 16'hDEAD;
  end
  assign a_rdata = a_p1;
  assign b_rdata = b_p2;
  assign c_rdata = c_p0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0; total = 0; failed = 0;
    rst = 1'b1; redirect = 1'b0; halt = 1'b0; out_ready = 1'b1; redirect_pc = 16'h0;
    s_rst = 1'b1; s_redirect = 1'b0; s_halt = 1'b0; s_ready = 1'b0; s_rpc = 16'h0;
    pops_b = 0; pops_c = 0; exp_b = 16'h0; exp_c = 16'h0;

    // Reset state
    repeat (3) cyc();
    #1;
    check("rst_ren",   32'(a_ren),   32'd0);
    check("rst_vld",   32'(a_vld),   32'd0);
    check("rst_inst",  32'(a_inst),  32'd0);
    check("rst_pc",    32'(a_pc),    32'd0);
    check("rst_occ",   32'(a_occ),   32'd0);
    check("rst_raddr", 32'(a_raddr), 32'h0);

    // Stream from reset: cycle 0 issues PC 0, first delivery at cycle 3
    rst = 1'b0;
    #1;
    check("c0_ren",   32'(a_ren),   32'd1);
    check("c0_raddr", 32'(a_raddr), 32'h0);
    cyc(); #1;
    check("c1_raddr", 32'(a_raddr), 32'h1);
    check("c1_vld",   32'(a_vld),   32'd0);
    cyc(); #1;
    check("c2_vld",   32'(a_vld),   32'd0);
    cyc(); #1;
    check("c3_vld",   32'(a_vld),   32'd1);
    check("c3_pc",    32'(a_pc),    32'h0);
    check("c3_inst",  32'(a_inst),  32'(img(16'h0)));
    for (int k = 1; k <= 3; k++) begin
      cyc(); #1;
      check("stream_pc",   32'(a_pc),   32'(k));
      check("stream_inst", 32'(a_inst), 32'(img(16'(k))));
    end

    // Backpressure: 10 cycles with out_ready low, head stays at PC 4
    cyc(); out_ready = 1'b0; #1;
    check("bp_head", 32'(a_pc), 32'h4);
    cyc(); #1;
    cyc(); #1;
    check("bp_occ3", 32'(a_occ), 32'd3);
    repeat (7) cyc();
    #1;
    check("bp_occ4", 32'(a_occ), 32'd4);
    check("bp_ren",  32'(a_ren), 32'd0);
    check("bp_pc",   32'(a_pc),  32'h4);
    cyc(); out_ready = 1'b1; #1;
    check("rel_pc4",  32'(a_pc),  32'h4);
    check("rel_ren",  32'(a_ren), 32'd0);
    for (int k = 5; k <= 10; k++) begin
      cyc(); #1;
      check("rel_vld",  32'(a_vld),  32'd1);
      check("rel_pc",   32'(a_pc),   32'(k));
      check("rel_inst", 32'(a_inst), 32'(img(16'(k))));
    end

    // Redirect in the same cycle as a pop and a capture
    cyc(); redirect = 1'b1; redirect_pc = 16'h0040; #1;
    check("rd_vld_before", 32'(a_vld), 32'd1);
    check("rd_pc_before",  32'(a_pc),  32'hB);
    check("rd_ren",        32'(a_ren), 32'd0);
    cyc(); redirect = 1'b0; #1;
    check("rd_occ",   32'(a_occ),   32'd0);
    check("rd_vld",   32'(a_vld),   32'd0);
    check("rd_raddr", 32'(a_raddr), 32'h40);
    check("rd_issue", 32'(a_ren),   32'd1);
    cyc(); #1;
    check("rd_gap1", 32'(a_vld), 32'd0);
    cyc(); #1;
    check("rd_gap2", 32'(a_vld), 32'd0);
    cyc(); #1;
    check("rd_first_vld",  32'(a_vld),  32'd1);
    check("rd_first_pc",   32'(a_pc),   32'h40);
    check("rd_first_inst", 32'(a_inst), 32'(img(16'h40)));
    cyc(); #1;
    check("rd_pc41", 32'(a_pc), 32'h41);
    cyc(); #1;
    check("rd_pc42", 32'(a_pc), 32'h42);

    // rst together with redirect: reset PC wins
    cyc(); rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h1234; #1;
    check("rr_ren", 32'(a_ren), 32'd0);
    cyc(); rst = 1'b0; redirect = 1'b0; #1;
    check("rr_raddr", 32'(a_raddr), 32'h0);
    check("rr_occ",   32'(a_occ),   32'd0);
    check("rr_ren1",  32'(a_ren),   32'd1);
    repeat (3) cyc();
    #1;
    check("rr_vld", 32'(a_vld), 32'd1);
    check("rr_pc",  32'(a_pc),  32'h0);

    // Wrap past 0xFFFF, then halt after the issue of 0x0000
    cyc(); redirect = 1'b1; redirect_pc = 16'hFFFE; #1;
    cyc(); redirect = 1'b0; #1;
    check("wr_raddr0", 32'(a_raddr), 32'hFFFE);
    cyc(); #1;
    check("wr_raddr1", 32'(a_raddr), 32'hFFFF);
    cyc(); #1;
    check("wr_raddr2", 32'(a_raddr), 32'h0000);
    check("wr_ren2",   32'(a_ren),   32'd1);
    cyc(); halt = 1'b1; #1;
    check("hl_ren0", 32'(a_ren), 32'd0);
    check("hl_pc0",  32'(a_pc),  32'hFFFE);
    cyc(); #1;
    check("hl_ren1", 32'(a_ren), 32'd0);
    check("hl_pc1",  32'(a_pc),  32'hFFFF);
    cyc(); #1;
    check("hl_ren2",  32'(a_ren),  32'd0);
    check("hl_pc2",   32'(a_pc),   32'h0000);
    check("hl_inst2", 32'(a_inst), 32'(img(16'h0)));
    cyc(); #1;
    check("hl_empty", 32'(a_vld), 32'd0);
    check("hl_occ",   32'(a_occ), 32'd0);
    repeat (3) cyc();
    #1;
    check("hl_ren_idle", 32'(a_ren),   32'd0);
    check("hl_raddr",    32'(a_raddr), 32'h1);
    cyc(); halt = 1'b0; #1;
    check("hl_resume_ren",   32'(a_ren),   32'd1);
    check("hl_resume_raddr", 32'(a_raddr), 32'h1);
    repeat (3) cyc();
    #1;
    check("hl_resume_vld", 32'(a_vld), 32'd1);
    check("hl_resume_pc",  32'(a_pc),  32'h1);

    // Parameter sweep: random handshake, halts and redirects
    rst = 1'b1;
    cyc(); s_rst = 1'b0;
    for (int n = 0; n < 800; n++) begin
      s_ready    = ($urandom_range(0, 3) != 0);
      s_redirect = ($urandom_range(0, 29) == 0);
      s_halt     = ($urandom_range(0, 9) == 0);
      s_rpc      = 16'($urandom);
      #1;
      if (s_redirect) begin
        exp_b = s_rpc;
        exp_c = s_rpc;
      end else begin
        if (b_vld && s_ready) begin
          check("b_pc",   32'(b_pc),   32'(exp_b));
          check("b_inst", 32'(b_inst), 32'(img(exp_b)));
          exp_b = exp_b + 16'd1;
          pops_b++;
        end
        if (c_vld && s_ready) begin
          check("c_pc",   32'(c_pc),   32'(exp_c));
          check("c_inst", 32'(c_inst), 32'(img(exp_c)));
          exp_c = exp_c + 16'd1;
          pops_c++;
        end
      end
      cyc();
    end
    check("b_progress", 32'(pops_b > 50), 32'd1);
    check("c_progress", 32'(pops_c > 50), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
